// File: rtl/key_filter_multi.sv
// Multi-channel key filter: 2-flop sync, tick-sampled debounce,
// Press/Release/Held outputs and optional auto-repeat on Out.
module key_filter_multi #(
    parameter int N                   = 4,
    parameter int TICK_DIV            = 50_000,
    parameter int DEBOUNCE_TICKS      = 20,
    parameter int REPEAT_DELAY_TICKS  = 500,
    parameter int REPEAT_PERIOD_TICKS = 100,
    parameter int CNT_W               = 10
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic [N-1:0] In,
    input  logic [N-1:0] RepeatEn,
    output logic [N-1:0] Press,
    output logic [N-1:0] Release,
    output logic [N-1:0] Out,
    output logic [N-1:0] Held,
    output logic         Strobe
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0]    P_LAST = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_N   = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] RD_N   = CNT_W'(REPEAT_DELAY_TICKS);
    localparam logic [CNT_W-1:0] RD_SAT = CNT_W'(REPEAT_DELAY_TICKS - 1);
    localparam logic [CNT_W-1:0] RP_N   = CNT_W'(REPEAT_PERIOD_TICKS);
    localparam bit               DB_ONE = (DEBOUNCE_TICKS == 1);

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        HOLD_DELAY,
        HOLD_REPEAT,
        DB_RELEASE
    } state_t;

    logic [PW-1:0] pcnt;
    logic          tick;
    logic [N-1:0]  sync1;
    logic [N-1:0]  s;

    assign tick = (pcnt == P_LAST);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            pcnt   <= '0;
            Strobe <= 1'b0;
            sync1  <= '0;
            s      <= '0;
        end else begin
            pcnt   <= tick ? '0 : pcnt + PW'(1);
            Strobe <= tick;
            sync1  <= In;
            s      <= sync1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t           st, st_n;
        logic [CNT_W-1:0] cnt, cnt_n;
        logic             press_n, rel_n, out_n, held_n;
        logic             press_q, rel_q, out_q, held_q;

        always_ff @(posedge Clock) begin
            if (!Resetn) begin
                st      <= IDLE;
                cnt     <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                out_q   <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                st      <= st_n;
                cnt     <= cnt_n;
                press_q <= press_n;
                rel_q   <= rel_n;
                out_q   <= out_n;
                held_q  <= held_n;
            end
        end

        always_comb begin
            st_n    = st;
            cnt_n   = cnt;
            press_n = 1'b0;
            rel_n   = 1'b0;
            out_n   = 1'b0;
            if (tick) begin
                unique case (st)
                    IDLE: begin
                        if (s[i]) begin
                            if (DB_ONE) begin
                                st_n    = HOLD_DELAY;
                                cnt_n   = '0;
                                press_n = 1'b1;
                                out_n   = 1'b1;
                            end else begin
                                st_n  = DB_PRESS;
                                cnt_n = ONE;
                            end
                        end
                    end
                    DB_PRESS: begin
                        if (!s[i]) begin
                            st_n  = IDLE;
                            cnt_n = '0;
                        end else if (cnt + ONE == DB_N) begin
                            st_n    = HOLD_DELAY;
                            cnt_n   = '0;
                            press_n = 1'b1;
                            out_n   = 1'b1;
                        end else begin
                            cnt_n = cnt + ONE;
                        end
                    end
                    HOLD_DELAY: begin
                        if (!s[i]) begin
                            if (DB_ONE) begin
                                st_n  = IDLE;
                                cnt_n = '0;
                                rel_n = 1'b1;
                            end else begin
                                st_n  = DB_RELEASE;
                                cnt_n = ONE;
                            end
                        end else if (RepeatEn[i] && (cnt + ONE == RD_N)) begin
                            st_n  = HOLD_REPEAT;
                            cnt_n = '0;
                            out_n = 1'b1;
                        end else if (cnt != RD_SAT) begin
                            cnt_n = cnt + ONE;
                        end
                    end
                    HOLD_REPEAT: begin
                        if (!s[i]) begin
                            if (DB_ONE) begin
                                st_n  = IDLE;
                                cnt_n = '0;
                                rel_n = 1'b1;
                            end else begin
                                st_n  = DB_RELEASE;
                                cnt_n = ONE;
                            end
                        end else if (!RepeatEn[i]) begin
                            // park saturated so re-enabling repeats on the next tick
                            st_n  = HOLD_DELAY;
                            cnt_n = RD_SAT;
                        end else if (cnt + ONE == RP_N) begin
                            cnt_n = '0;
                            out_n = 1'b1;
                        end else begin
                            cnt_n = cnt + ONE;
                        end
                    end
                    DB_RELEASE: begin
                        if (s[i]) begin
                            st_n  = HOLD_DELAY;
                            cnt_n = '0;
                        end else if (cnt + ONE == DB_N) begin
                            st_n  = IDLE;
                            cnt_n = '0;
                            rel_n = 1'b1;
                        end else begin
                            cnt_n = cnt + ONE;
                        end
                    end
                    default: begin
                        st_n  = IDLE;
                        cnt_n = '0;
                    end
                endcase
            end
            held_n = (st_n == HOLD_DELAY) || (st_n == HOLD_REPEAT) ||
                     (st_n == DB_RELEASE);
        end

        assign Press[i]   = press_q;
        assign Release[i] = rel_q;
        assign Out[i]     = out_q;
        assign Held[i]    = held_q;
    end

endmodule

// File: tb/tb_key_filter_multi.sv
// Directed bench for key_filter_multi: N=2, TICK_DIV=4, debounce 3,
// repeat delay 5, repeat period 2.
module tb_key_filter_multi;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic [1:0] In;
    logic [1:0] RepeatEn;
    logic [1:0] Press;
    logic [1:0] Release;
    logic [1:0] Out;
    logic [1:0] Held;
    logic       Strobe;

    int n_cmp = 0;
    int n_err = 0;
    int n     = 0;

    key_filter_multi #(
        .N                  (2),
        .TICK_DIV           (4),
        .DEBOUNCE_TICKS     (3),
        .REPEAT_DELAY_TICKS (5),
        .REPEAT_PERIOD_TICKS(2),
        .CNT_W              (4)
    ) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .In      (In),
        .RepeatEn(RepeatEn),
        .Press   (Press),
        .Release (Release),
        .Out     (Out),
        .Held    (Held),
        .Strobe  (Strobe)
    );

    always #5 Clock = ~Clock;

    function automatic logic [8:0] obs();
        return {Strobe, Held, Out, Release, Press};
    endfunction

    task automatic chk(input string tag, input logic [8:0] o,
                       input logic [8:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b (n=%0d)", tag, o, e, n);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        @(negedge Clock);
        n++;
    endtask

    // advance to the next Strobe cycle; pulses must stay low in between
    task automatic tk();
        do begin
            cyc();
            if (n % 4 != 0)
                chk("gap", {Strobe, 2'b00, Out, Release, Press}, 9'd0);
        end while (n % 4 != 0);
    endtask

    task automatic ex(input string tag, input logic [1:0] p,
                      input logic [1:0] r, input logic [1:0] o,
                      input logic [1:0] h);
        tk();
        chk(tag, obs(), {1'b1, h, o, r, p});
    endtask

    initial begin
        logic       sb;
        logic [1:0] eo;

        Resetn   = 1'b0;
        In       = 2'b11;
        RepeatEn = 2'b00;
        repeat (5) begin
            cyc();
            chk("reset", obs(), 9'd0);
        end
        Resetn = 1'b1;
        In     = 2'b00;
        n      = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            sb = (n % 4 == 0);
            chk("strobe", obs(), {sb, 8'd0});
        end

        // single-cycle glitch between ticks
        In = 2'b01;
        cyc();
        chk("glitch_gap", obs(), 9'd0);
        In = 2'b00;
        ex("glitch1", 2'b00, 2'b00, 2'b00, 2'b00);
        ex("glitch2", 2'b00, 2'b00, 2'b00, 2'b00);

        // two-sample bounce
        In = 2'b01;
        ex("bounce1", 2'b00, 2'b00, 2'b00, 2'b00);
        ex("bounce2", 2'b00, 2'b00, 2'b00, 2'b00);
        In = 2'b00;
        ex("bounce3", 2'b00, 2'b00, 2'b00, 2'b00);
        ex("bounce4", 2'b00, 2'b00, 2'b00, 2'b00);

        // clean press, no repeat
        In = 2'b01;
        ex("db1", 2'b00, 2'b00, 2'b00, 2'b00);
        ex("db2", 2'b00, 2'b00, 2'b00, 2'b00);
        ex("press", 2'b01, 2'b00, 2'b01, 2'b01);
        for (int t = 1; t <= 14; t++)
            ex("norep", 2'b00, 2'b00, 2'b00, 2'b01);

        // enable repeat with delay already saturated
        RepeatEn = 2'b01;
        ex("late_rep", 2'b00, 2'b00, 2'b01, 2'b01);
        ex("late_gap", 2'b00, 2'b00, 2'b00, 2'b01);
        ex("late_rep2", 2'b00, 2'b00, 2'b01, 2'b01);

        // release
        In = 2'b00;
        ex("rel1", 2'b00, 2'b00, 2'b00, 2'b01);
        ex("rel2", 2'b00, 2'b00, 2'b00, 2'b01);
        ex("release", 2'b00, 2'b01, 2'b00, 2'b00);
        ex("idle", 2'b00, 2'b00, 2'b00, 2'b00);

        // fresh press with auto-repeat
        In = 2'b01;
        ex("rdb1", 2'b00, 2'b00, 2'b00, 2'b00);
        ex("rdb2", 2'b00, 2'b00, 2'b00, 2'b00);
        ex("rpress", 2'b01, 2'b00, 2'b01, 2'b01);
        for (int t = 1; t <= 14; t++) begin
            eo = (t == 5 || t == 7 || t == 9 || t == 11 || t == 13)
                 ? 2'b01 : 2'b00;
            ex("repeat", 2'b00, 2'b00, eo, 2'b01);
        end

        // one-sample dip restarts the repeat delay
        In = 2'b00;
        ex("dip", 2'b00, 2'b00, 2'b00, 2'b01);
        In = 2'b01;
        ex("dip_back", 2'b00, 2'b00, 2'b00, 2'b01);
        for (int t = 1; t <= 4; t++)
            ex("dip_wait", 2'b00, 2'b00, 2'b00, 2'b01);
        ex("dip_rep", 2'b00, 2'b00, 2'b01, 2'b01);
        ex("dip_gap", 2'b00, 2'b00, 2'b00, 2'b01);
        ex("dip_rep2", 2'b00, 2'b00, 2'b01, 2'b01);

        // ch1 press/release while ch0 repeats
        In = 2'b11;
        ex("ind24", 2'b00, 2'b00, 2'b00, 2'b01);
        ex("ind25", 2'b00, 2'b00, 2'b01, 2'b01);
        ex("ind26", 2'b10, 2'b00, 2'b10, 2'b11);
        ex("ind27", 2'b00, 2'b00, 2'b01, 2'b11);
        In = 2'b01;
        ex("ind28", 2'b00, 2'b00, 2'b00, 2'b11);
        ex("ind29", 2'b00, 2'b00, 2'b01, 2'b11);
        ex("ind30", 2'b00, 2'b10, 2'b00, 2'b01);

        // reset in the middle of a hold
        Resetn = 1'b0;
        cyc();
        chk("rst_mid1", obs(), 9'd0);
        cyc();
        chk("rst_mid2", obs(), 9'd0);
        Resetn   = 1'b1;
        In       = 2'b00;
        RepeatEn = 2'b00;
        n        = 0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            sb = (n % 4 == 0);
            chk("rst_after", obs(), {sb, 8'd0});
        end
        ex("rst_idle", 2'b00, 2'b00, 2'b00, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
